// File: rtl/bec_pkg.sv
// Shared types and constants for the bec event-capture trace stage.
package bec_pkg;

  // Strobe vector width (y1 = bit 0 ... y39 = bit 38) and timestamp width
  localparam int BEC_VEC_W = 39;
  localparam int BEC_TS_W  = 16;

  // Capture controller states, encoded as seen on the cap_state output
  typedef enum logic [1:0] {
    CS_IDLE    = 2'd0,
    CS_ARMED   = 2'd1,
    CS_CAPTURE = 2'd2,
    CS_DONE    = 2'd3
  } cap_state_t;

  // One recorded event: strobe vector plus the timestamp of its edge
  typedef struct packed {
    logic [BEC_VEC_W-1:0] vec;
    logic [BEC_TS_W-1:0]  ts;
  } evt_t;

endpackage

// File: rtl/bec_evt_fifo.sv
// Synchronous FIFO for captured events. The head entry is read straight out
// of storage, so a push at edge k is visible on dout right after edge k.
// A push while full is accepted only when a pop happens in the same cycle.
module bec_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 55
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             wr_en;
  logic             rd_en;

  // full/empty come from the level count; pointers simply wrap
  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & ~clr & (~full | rd_en);

  // Storage write; contents are only meaningful below the level count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and level bookkeeping; clr empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (wr_en && !rd_en) begin
        level_reg <= level_reg + LVL_W'(1);
      end else if (rd_en && !wr_en) begin
        level_reg <= level_reg - LVL_W'(1);
      end
    end
  end

  // Empty queue shows zeros rather than stale storage
  assign dout  = empty ? '0 : mem[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/bec_evt_capture.sv
// Trace stage behind the bec controller: timestamps every edge, arms on
// request, triggers on a masked strobe and records POST nonzero-strobe events
// into a FIFO that a host drains over valid/ready.
module bec_evt_capture
  import bec_pkg::*;
#(
  parameter int VEC_W = BEC_VEC_W,
  parameter int DEPTH = 8,
  parameter int TS_W  = BEC_TS_W,
  parameter int POST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VEC_W-1:0]           y_vec,
  input  logic                       arm,
  input  logic                       clr,
  input  logic [VEC_W-1:0]           trig_mask,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [VEC_W-1:0]           rd_vec,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [1:0]                 cap_state
);

  localparam int PC_W = (POST > 1) ? $clog2(POST) : 1;

  cap_state_t       state_reg;
  cap_state_t       state_next;
  logic [TS_W-1:0]  ts_reg;
  logic [PC_W-1:0]  post_cnt_reg;
  logic [PC_W-1:0]  post_cnt_next;
  logic             overflow_reg;
  logic [7:0]       drop_cnt_reg;

  logic             evt;
  logic             trig;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [VEC_W+TS_W-1:0] fifo_dout;

  assign evt  = |y_vec;
  assign trig = |(y_vec & trig_mask);

  // Free-running timestamp; only rst touches it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_reg <= '0;
    else     ts_reg <= ts_reg + TS_W'(1);
  end

  // Capture state and remaining-event counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= CS_IDLE;
      post_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      post_cnt_reg <= post_cnt_next;
    end
  end

  // Next state: clr wins, then arm, then events. arm in ARMED re-arms and
  // discards a coincident trigger; arm is ignored while capturing.
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = CS_IDLE;
    end else begin
      case (state_reg)
        CS_IDLE:    if (arm) state_next = CS_ARMED;
        CS_ARMED:   if (!arm && trig) state_next = (POST == 1) ? CS_DONE : CS_CAPTURE;
        CS_CAPTURE: if (evt && post_cnt_reg == PC_W'(1)) state_next = CS_DONE;
        CS_DONE:    if (arm) state_next = CS_ARMED;
        default:    state_next = CS_IDLE;
      endcase
    end
  end

  // Outputs of the controller: which edges push and how the counter moves.
  // Dropped pushes still consume one of the POST slots.
  always_comb begin
    push_req      = 1'b0;
    post_cnt_next = post_cnt_reg;
    if (!clr) begin
      case (state_reg)
        CS_ARMED: begin
          if (!arm && trig) begin
            push_req      = 1'b1;
            post_cnt_next = PC_W'(POST - 1);
          end
        end
        CS_CAPTURE: begin
          if (evt) begin
            push_req      = 1'b1;
            post_cnt_next = post_cnt_reg - PC_W'(1);
          end
        end
        default: begin
          push_req      = 1'b0;
          post_cnt_next = post_cnt_reg;
        end
      endcase
    end
  end

  assign pop  = rd_ready & ~fifo_empty;
  assign drop = push_req & fifo_full & ~pop;

  // Sticky overflow flag and saturating drop counter; both cleared by clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (clr) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  bec_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (VEC_W + TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_req),
    .pop   (pop),
    .din   ({y_vec, ts_reg}),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_valid  = ~fifo_empty;
  assign rd_vec    = fifo_dout[VEC_W+TS_W-1:TS_W];
  assign rd_ts     = fifo_dout[TS_W-1:0];
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign cap_state = state_reg;

endmodule

// File: tb/tb_bec_evt_capture.sv
// Bench for bec_evt_capture: two instances (POST=4 and POST=12) share one
// stimulus stream; a list-based reference model predicts both every cycle.
module tb_bec_evt_capture;
  import bec_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [38:0] TRIG = 39'h04_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        clr = 1'b0;
  logic        rd_ready = 1'b0;
  logic [38:0] y_vec = '0;
  logic [38:0] trig_mask = '0;

  logic        rd_valid_w [2];
  logic [38:0] rd_vec_w   [2];
  logic [15:0] rd_ts_w    [2];
  logic [3:0]  level_w    [2];
  logic        overflow_w [2];
  logic [7:0]  drop_w     [2];
  logic [1:0]  state_w    [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b1;

  always #5 clk = ~clk;

  bec_evt_capture #(.DEPTH(DEPTH), .POST(4)) dut4 (
    .clk(clk), .rst(rst), .y_vec(y_vec), .arm(arm), .clr(clr), .trig_mask(trig_mask),
    .rd_valid(rd_valid_w[0]), .rd_ready(rd_ready), .rd_vec(rd_vec_w[0]), .rd_ts(rd_ts_w[0]),
    .level(level_w[0]), .overflow(overflow_w[0]), .drop_cnt(drop_w[0]), .cap_state(state_w[0])
  );

  bec_evt_capture #(.DEPTH(DEPTH), .POST(12)) dut12 (
    .clk(clk), .rst(rst), .y_vec(y_vec), .arm(arm), .clr(clr), .trig_mask(trig_mask),
    .rd_valid(rd_valid_w[1]), .rd_ready(rd_ready), .rd_vec(rd_vec_w[1]), .rd_ts(rd_ts_w[1]),
    .level(level_w[1]), .overflow(overflow_w[1]), .drop_cnt(drop_w[1]), .cap_state(state_w[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: list of stored events (index 0 = oldest), phase
  // 0 idle / 1 armed / 2 capturing / 3 done, events still to record.
  evt_t        m_buf  [2][DEPTH];
  int          m_cnt  [2];
  int          m_state[2];
  int          m_rem  [2];
  int          m_drop [2];
  bit          m_ovf  [2];
  logic [15:0] m_ts;

  always @(posedge clk) begin
    bit ev, tr, pop, rec;
    ev = (y_vec != '0);
    tr = ((y_vec & trig_mask) != '0);
    if (rst) begin
      m_ts = '0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_state[i] = 0; m_rem[i] = 0; m_drop[i] = 0; m_ovf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pop = (m_cnt[i] != 0) && rd_ready;
        rec = 1'b0;
        if (clr) begin
          m_cnt[i] = 0; m_ovf[i] = 1'b0; m_drop[i] = 0; m_state[i] = 0;
        end else begin
          case (m_state[i])
            0: if (arm) m_state[i] = 1;
            1: if (!arm && tr) begin
                 rec = 1'b1;
                 m_rem[i] = ((i == 0) ? 4 : 12) - 1;
                 m_state[i] = (m_rem[i] == 0) ? 3 : 2;
               end
            2: if (ev) begin
                 rec = 1'b1;
                 m_rem[i] = m_rem[i] - 1;
                 if (m_rem[i] == 0) m_state[i] = 3;
               end
            default: if (arm) m_state[i] = 1;
          endcase
          if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) m_buf[i][k] = m_buf[i][k+1];
            m_cnt[i] = m_cnt[i] - 1;
          end
          if (rec) begin
            if (m_cnt[i] < DEPTH) begin
              m_buf[i][m_cnt[i]] = {y_vec, m_ts};
              m_cnt[i] = m_cnt[i] + 1;
            end else begin
              m_ovf[i] = 1'b1;
              if (m_drop[i] < 255) m_drop[i] = m_drop[i] + 1;
            end
          end
        end
      end
      m_ts = m_ts + 16'd1;
    end
  end

  // Compare both instances against the model shortly after every edge
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc.rd_valid[%0d]", i), 64'(rd_valid_w[i]), 64'(m_cnt[i] != 0));
        chk($sformatf("cyc.level[%0d]", i), 64'(level_w[i]), 64'(m_cnt[i]));
        chk($sformatf("cyc.overflow[%0d]", i), 64'(overflow_w[i]), 64'(m_ovf[i]));
        chk($sformatf("cyc.drop_cnt[%0d]", i), 64'(drop_w[i]), 64'(m_drop[i]));
        chk($sformatf("cyc.cap_state[%0d]", i), 64'(state_w[i]), 64'(m_state[i]));
        if (m_cnt[i] != 0) begin
          chk($sformatf("cyc.rd_vec[%0d]", i), 64'(rd_vec_w[i]), 64'(m_buf[i][0].vec));
          chk($sformatf("cyc.rd_ts[%0d]", i), 64'(rd_ts_w[i]), 64'(m_buf[i][0].ts));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs at a falling edge and return at the next falling edge
  task automatic cyc(input logic [38:0] y, input logic a, input logic c, input logic r);
    y_vec = y; arm = a; clr = c; rd_ready = r;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.rd_valid[%0d]", tag, i), 64'(rd_valid_w[i]), 64'd0);
      chk($sformatf("%s.rd_vec[%0d]", tag, i), 64'(rd_vec_w[i]), 64'd0);
      chk($sformatf("%s.rd_ts[%0d]", tag, i), 64'(rd_ts_w[i]), 64'd0);
      chk($sformatf("%s.level[%0d]", tag, i), 64'(level_w[i]), 64'd0);
      chk($sformatf("%s.overflow[%0d]", tag, i), 64'(overflow_w[i]), 64'd0);
      chk($sformatf("%s.drop_cnt[%0d]", tag, i), 64'(drop_w[i]), 64'd0);
      chk($sformatf("%s.cap_state[%0d]", tag, i), 64'(state_w[i]), 64'd0);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // Trigger on bit 34, POST=4 instance fills four entries
    trig_mask = TRIG;
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("t2.armed4", 64'(state_w[0]), 64'd1);
    cyc(39'h1, 1'b0, 1'b0, 1'b0);
    chk("t2.nopush", 64'(level_w[0]), 64'd0);
    cyc(39'h0C_0000_0000, 1'b0, 1'b0, 1'b0);
    chk("t2.trig_level", 64'(level_w[0]), 64'd1);
    chk("t2.trig_vec", 64'(rd_vec_w[0]), 64'h0C_0000_0000);
    chk("t2.trig_ts", 64'(rd_ts_w[0]), 64'd2);
    chk("t2.capture4", 64'(state_w[0]), 64'd2);
    cyc(39'h3, 1'b0, 1'b0, 1'b0);
    cyc(39'h5, 1'b0, 1'b0, 1'b0);
    cyc(39'h7, 1'b0, 1'b0, 1'b0);
    cyc(39'h9, 1'b0, 1'b0, 1'b0);
    chk("t2.done4", 64'(state_w[0]), 64'd3);
    chk("t2.level4", 64'(level_w[0]), 64'd4);
    chk("t2.level12", 64'(level_w[1]), 64'd5);

    // Overflow on the POST=12 instance: seven more events, no reads
    for (int k = 1; k <= 7; k++) cyc(39'h100 + 39'(k), 1'b0, 1'b0, 1'b0);
    chk("t3.level12", 64'(level_w[1]), 64'd8);
    chk("t3.ovf12", 64'(overflow_w[1]), 64'd1);
    chk("t3.drop12", 64'(drop_w[1]), 64'd4);
    chk("t3.done12", 64'(state_w[1]), 64'd3);
    chk("t3.ovf4", 64'(overflow_w[0]), 64'd0);

    // Full FIFO with simultaneous pop while capturing
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc(TRIG, 1'b0, 1'b0, 1'b1);
    cyc(39'h55, 1'b0, 1'b0, 1'b1);
    chk("t4.level12", 64'(level_w[1]), 64'd8);
    chk("t4.drop12", 64'(drop_w[1]), 64'd4);
    chk("t4.capture12", 64'(state_w[1]), 64'd2);
    repeat (7) cyc('0, 1'b0, 1'b0, 1'b1);
    chk("t4.tail_level", 64'(level_w[1]), 64'd1);
    chk("t4.tail_vec", 64'(rd_vec_w[1]), 64'h55);
    chk("t4.drained4", 64'(rd_valid_w[0]), 64'd0);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // Timestamp wrap and backpressure
    cmp_en = 1'b0;
    for (int n = 0; n < 70000 && m_ts != 16'hFFFF; n++) cyc('0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    chk("t5.wait_ts", 64'(m_ts), 64'hFFFF);
    cyc(39'h11, 1'b0, 1'b0, 1'b0);
    cyc(39'h22, 1'b0, 1'b0, 1'b0);
    chk("t5.done4", 64'(state_w[0]), 64'd3);
    for (int k = 0; k < 3; k++) begin
      cyc('0, 1'b0, 1'b0, 1'b0);
      chk("t5.hold_ts", 64'(rd_ts_w[0]), 64'hFFFF);
      chk("t5.hold_vec", 64'(rd_vec_w[1]), 64'h11);
    end
    cyc('0, 1'b0, 1'b0, 1'b1);
    chk("t5.wrap_ts", 64'(rd_ts_w[0]), 64'h0000);
    chk("t5.wrap_vec", 64'(rd_vec_w[0]), 64'h22);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // clr during capture together with an event
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("t6.arm_ignored12", 64'(state_w[1]), 64'd2);
    cyc(TRIG, 1'b0, 1'b0, 1'b0);
    chk("t6.ovf_kept12", 64'(overflow_w[1]), 64'd1);
    cyc(39'h3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("t6.level", 64'(level_w[i]), 64'd0);
      chk("t6.ovf", 64'(overflow_w[i]), 64'd0);
      chk("t6.drop", 64'(drop_w[i]), 64'd0);
      chk("t6.state", 64'(state_w[i]), 64'd0);
    end
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("t6.rearm4", 64'(state_w[0]), 64'd1);
    chk("t6.rearm12", 64'(state_w[1]), 64'd1);

    // Asynchronous reset in the middle of a capture
    cyc(TRIG, 1'b0, 1'b0, 1'b0);
    chk("t1.pre_level", 64'(level_w[0]), 64'd1);
    y_vec = '0;
    rst = 1'b1;
    #1;
    chk_zero("t1.rst");
    @(negedge clk);
    rst = 1'b0;
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    chk("t1.idle", 64'(state_w[1]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
